// File: rtl/truth_table_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sequencer_pkg
// Brief    : State encodings and golden truth tables for exercise sequencers.
// Revision : 1.0 - initial release
// ============================================================================
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam int unsigned CNT_W = 4;

  // Golden table for f = (a & b) | (c & ~b), index {a,b,c}
  localparam logic [7:0] EXP_EX5 = 8'hE2;

  function automatic logic [CNT_W-1:0] settle_load(input int unsigned settle);
    return CNT_W'(settle - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/settle_counter.sv
`default_nettype none
// ============================================================================
// Module   : settle_counter
// Brief    : Loadable 4-bit down-counter; tc flags a count of zero.
// Revision : 1.0 - initial release
// ============================================================================
module settle_counter
  import truth_table_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sequencer
// Brief    : Sweeps all input vectors of an exercise DUT, captures its truth
//            table and compares it against a golden constant.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int unsigned          N_IN     = 3,
  parameter int unsigned          SETTLE   = 2,
  parameter logic [(2**N_IN)-1:0] EXPECTED = EXP_EX5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   dut_out,
  output logic [N_IN-1:0]        dut_in,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   table_out,
  output logic                   pass
);

  localparam int unsigned      c_tbl_w    = 2**N_IN;
  localparam logic [N_IN-1:0]  c_last_idx = '1;
  localparam logic [CNT_W-1:0] c_load_val = settle_load(SETTLE);

  state_t              r_state;
  logic [N_IN-1:0]     r_idx;
  logic [c_tbl_w-1:0]  w_next_table;
  logic                w_last;
  logic                w_load;
  logic                w_settled;

  assign w_last = (r_idx == c_last_idx);

  // Reload the hold counter at sweep start and when moving to the next vector
  assign w_load = ((r_state == S_IDLE) && start) ||
                  ((r_state == S_SAMPLE) && !abort && !w_last);

  always_comb begin
    w_next_table        = table_out;
    w_next_table[r_idx] = dut_out;
  end

  settle_counter u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (c_load_val),
    .en       (r_state == S_APPLY),
    .tc       (w_settled)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      pass      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_APPLY;
            r_idx     <= '0;
            dut_in    <= '0;
            busy      <= 1'b1;
            table_out <= '0;
            pass      <= 1'b0;
          end
        end
        S_APPLY: begin
          if (abort) begin
            r_state <= S_IDLE;
            dut_in  <= '0;
            busy    <= 1'b0;
          end else if (w_settled) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            r_state <= S_IDLE;
            dut_in  <= '0;
            busy    <= 1'b0;
          end else begin
            table_out <= w_next_table;
            if (w_last) begin
              r_state <= S_FINISH;
              dut_in  <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (w_next_table == EXPECTED);
            end else begin
              r_state <= S_APPLY;
              r_idx   <= r_idx + 1'b1;
              dut_in  <= r_idx + 1'b1;
            end
          end
        end
        S_FINISH: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sequencer
// Brief    : Directed self-checking bench for truth_table_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, fault = 1'b0;
  logic       dut_out;
  logic [2:0] dut_in;
  logic       busy, done, pass;
  logic [7:0] table_out;

  logic       start2 = 1'b0, abort2 = 1'b0;
  logic       dut_out2;
  logic [2:0] dut_in2;
  logic       busy2, done2, pass2;
  logic [7:0] table_out2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Exercise DUT model: f = (a & b) | (c & ~b), dut_in = {a,b,c}
  always_comb begin
    dut_out  = fault ? 1'b0 : ((dut_in[2] & dut_in[1]) | (dut_in[0] & ~dut_in[1]));
    dut_out2 = (dut_in2[2] & dut_in2[1]) | (dut_in2[0] & ~dut_in2[1]);
  end

  truth_table_sequencer #(.N_IN(3), .SETTLE(2), .EXPECTED(8'hE2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_out(dut_out),
    .dut_in(dut_in), .busy(busy), .done(done), .table_out(table_out), .pass(pass)
  );

  truth_table_sequencer #(.N_IN(3), .SETTLE(1), .EXPECTED(8'hE2)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .dut_out(dut_out2),
    .dut_in(dut_in2), .busy(busy2), .done(done2), .table_out(table_out2), .pass(pass2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until done (or -1 if the budget expires)
  task automatic wait_done(input int max_cycles, input bit second, output int n);
    n = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      tick();
      if (second ? done2 : done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({dut_in, busy, done, table_out, pass} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_values: got dut_in=%0d busy=%b done=%b table=%h pass=%b, want all 0",
               dut_in, busy, done, table_out, pass);
    end
    n_checks++;
    if ({dut_in2, busy2, done2, table_out2, pass2} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_values_s1: got dut_in=%0d busy=%b done=%b table=%h pass=%b, want all 0",
               dut_in2, busy2, done2, table_out2, pass2);
    end
    rst = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_golden_sweep;
    fault = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      n_checks++;
      if ({dut_in, busy, done} !== {3'(k / 3), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL golden_step E0+%0d: got dut_in=%0d busy=%b done=%b, want dut_in=%0d busy=1 done=0",
                 k, dut_in, busy, done, k / 3);
      end
      tick();
    end
    n_checks++;
    if ({done, busy, table_out, pass} !== {1'b1, 1'b0, 8'hE2, 1'b1}) begin
      n_fail++;
      $display("FAIL golden_finish E0+24: got done=%b busy=%b table=%h pass=%b, want 1 0 e2 1",
               done, busy, table_out, pass);
    end
    tick();
    n_checks++;
    if ({done, busy, pass} !== 3'b001) begin
      n_fail++;
      $display("FAIL golden_after: got done=%b busy=%b pass=%b, want 0 0 1", done, busy, pass);
    end
  endtask

  task automatic test_faulty_dut;
    int n;
    fault = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, 1'b0, n);
    n_checks++;
    if (n != 24) begin
      n_fail++;
      $display("FAIL faulty_done_edge: got %0d, want 24", n);
    end
    n_checks++;
    if ({table_out, pass} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL faulty_table: got table=%h pass=%b, want 00 0", table_out, pass);
    end
    tick();
    fault = 1'b0;
  endtask

  task automatic test_abort;
    int n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    n_checks++;
    if ({dut_in, busy} !== {3'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_pre: got dut_in=%0d busy=%b, want 3 1", dut_in, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, dut_in, done, table_out, pass} !== {1'b0, 3'd0, 1'b0, 8'h02, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_state: got busy=%b dut_in=%0d done=%b table=%h pass=%b, want 0 0 0 02 0",
               busy, dut_in, done, table_out, pass);
    end
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) n_done++;
    end
    n_checks++;
    if ((n_done != 0) || busy) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done pulses busy=%b, want 0 0", n_done, busy);
    end
  endtask

  task automatic test_restart_ignored_start;
    int first_edge, n_done, n;
    start = 1'b1;
    tick();
    start = 1'b0;
    first_edge = -1;
    n_done = 0;
    for (int i = 1; i <= 30; i++) begin
      start = (i == 5) || (i == 20) || (i == 25);
      tick();
      if (done) begin
        n_done++;
        if (first_edge < 0) first_edge = i;
      end
    end
    start = 1'b0;
    n_checks++;
    if ((first_edge != 24) || (n_done != 1)) begin
      n_fail++;
      $display("FAIL ignored_start_done: got edge=%0d count=%0d, want edge=24 count=1",
               first_edge, n_done);
    end
    n_checks++;
    if ({busy, table_out, pass} !== {1'b0, 8'hE2, 1'b1}) begin
      n_fail++;
      $display("FAIL ignored_start_result: got busy=%b table=%h pass=%b, want 0 e2 1",
               busy, table_out, pass);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, table_out, pass} !== {1'b1, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL restart_clear: got busy=%b table=%h pass=%b, want 1 00 0", busy, table_out, pass);
    end
    wait_done(40, 1'b0, n);
    n_checks++;
    if ((n != 24) || ({table_out, pass} !== {8'hE2, 1'b1})) begin
      n_fail++;
      $display("FAIL restart_sweep: got edge=%0d table=%h pass=%b, want 24 e2 1", n, table_out, pass);
    end
    tick();
  endtask

  task automatic test_async_reset;
    int n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    n_checks++;
    if (dut_in !== 3'd5) begin
      n_fail++;
      $display("FAIL areset_pre: got dut_in=%0d, want 5", dut_in);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({dut_in, busy, done, table_out, pass} !== 14'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: got dut_in=%0d busy=%b done=%b table=%h pass=%b, want all 0",
               dut_in, busy, done, table_out, pass);
    end
    #2 rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) n_done++;
    end
    n_checks++;
    if ((n_done != 0) || ({busy, table_out} !== 9'd0)) begin
      n_fail++;
      $display("FAIL areset_after: got %0d done pulses busy=%b table=%h, want 0 0 00",
               n_done, busy, table_out);
    end
  endtask

  task automatic test_settle1;
    start2 = 1'b1;
    abort2 = 1'b1;
    tick();
    start2 = 1'b0;
    abort2 = 1'b0;
    n_checks++;
    if (busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL s1_start_wins: got busy=%b, want 1", busy2);
    end
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if ({dut_in2, busy2, done2} !== {3'(k / 2), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL s1_step E0+%0d: got dut_in=%0d busy=%b done=%b, want dut_in=%0d busy=1 done=0",
                 k, dut_in2, busy2, done2, k / 2);
      end
      tick();
    end
    n_checks++;
    if ({done2, busy2, table_out2, pass2} !== {1'b1, 1'b0, 8'hE2, 1'b1}) begin
      n_fail++;
      $display("FAIL s1_finish E0+16: got done=%b busy=%b table=%h pass=%b, want 1 0 e2 1",
               done2, busy2, table_out2, pass2);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_golden_sweep();
    test_faulty_dut();
    test_abort();
    test_restart_ignored_start();
    test_async_reset();
    test_settle1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
